// File: rtl/csi2_csr_pkg.sv
// CSI-2 receiver CSR map: register indices, counts, CLEAR_STAT bits.
// Optional IRQ_MASK register is present when CSI2_CSR_ERR_IRQ_EN is defined.
package csi2_csr_pkg;

   // Control registers (word offsets)
   localparam int CLEAR_STAT_CR      = 0;
   localparam int PHY_ENABLE_CR      = 1;
   localparam int SCCB_SLAVE_ADDR_CR = 2;
   localparam int TOTAL_CR_CNT       = 3;

   // Status registers (offsets from SR_BASE)
   localparam int SR_BASE               = TOTAL_CR_CNT;
   localparam int HEADER_ERR_CNT_SR     = 0;
   localparam int CORR_HEADER_ERR_CNT_SR = 1;
   localparam int CRC_ERR_CNT_SR        = 2;
   localparam int MAX_LN_PER_FRAME_SR   = 3;
   localparam int MIN_LN_PER_FRAME_SR   = 4;
   localparam int MAX_PX_PER_LN_SR      = 5;
   localparam int MIN_PX_PER_LN_SR      = 6;
   localparam int TOTAL_SR_CNT          = 7;

`ifdef CSI2_CSR_ERR_IRQ_EN
   // IRQ_MASK sits after the status block
   localparam int IRQ_MASK_CR    = SR_BASE + TOTAL_SR_CNT;
   localparam int TOTAL_REGS_CNT = TOTAL_CR_CNT + TOTAL_SR_CNT + 1;
`else
   localparam int TOTAL_REGS_CNT = TOTAL_CR_CNT + TOTAL_SR_CNT;
`endif

   // CLEAR_STAT bit positions
   localparam int CLR_STAT_BIT = 0;
   localparam int CLR_IRQ_BIT  = 1;

   // Error source index (counter slot and IRQ_MASK bit)
   localparam int ERR_HDR  = 0;
   localparam int ERR_CORR = 1;
   localparam int ERR_CRC  = 2;
   localparam int ERR_CNT  = 3;

endpackage

// File: rtl/csi2_minmax_tracker.sv
// Saturating event accumulator with MIN/MAX capture on commit.
// Ports: clear_i (sync reset of stats), count_i, commit_i, arm_i; max_o/min_o.
module csi2_minmax_tracker #(
   parameter int W          = 16,
   // commit value includes a same-cycle count_i
   parameter bit INCL_COUNT = 1'b0,
   // commits are ignored until arm_i has been seen once
   parameter bit NEED_ARM   = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clear_i,
   input  logic         count_i,
   input  logic         commit_i,
   input  logic         arm_i,
   output logic [W-1:0] max_o,
   output logic [W-1:0] min_o
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] max_q, max_d;
   logic [W-1:0] min_q, min_d;
   logic         armed_q, armed_d;
   logic [W-1:0] acc_inc;
   logic [W-1:0] cval;

   always_comb begin
      acc_d   = acc_q;
      max_d   = max_q;
      min_d   = min_q;
      armed_d = armed_q;
      acc_inc = (&acc_q) ? acc_q : acc_q + ONE;
      cval    = (INCL_COUNT && count_i) ? acc_inc : acc_q;
      if (clear_i) begin
         acc_d   = '0;
         max_d   = '0;
         min_d   = '1;
         armed_d = 1'b0;
      end else begin
         if (arm_i) armed_d = 1'b1;
         if (commit_i) begin
            if (armed_q || !NEED_ARM) begin
               if (cval > max_q) max_d = cval;
               if (cval < min_q) min_d = cval;
            end
            // a count not folded into the commit opens the next run
            acc_d = (!INCL_COUNT && count_i) ? ONE : '0;
         end else if (count_i) begin
            acc_d = acc_inc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q   <= '0;
         max_q   <= '0;
         min_q   <= '1;
         armed_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         max_q   <= max_d;
         min_q   <= min_d;
         armed_q <= armed_d;
      end
   end

   assign max_o = max_q;
   assign min_o = min_q;

endmodule

// File: rtl/csi2_csr_stat.sv
// CSI-2 RX CSR file + stats: CSR bus (1-cycle read), control outputs, error/line/px stats.
// Optional macro CSI2_CSR_ERR_IRQ_EN adds IRQ_MASK (word 10) and err_irq_o.
module csi2_csr_stat
   import csi2_csr_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 8,
   parameter int CNT_WIDTH       = 16,
   parameter int SCCB_ADDR_WIDTH = 7
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic [ADDR_WIDTH-1:0]      csr_addr_i,
   input  logic                       csr_wr_i,
   input  logic [DATA_WIDTH-1:0]      csr_wr_data_i,
   input  logic                       csr_rd_i,
   output logic [DATA_WIDTH-1:0]      csr_rd_data_o,
   output logic                       csr_rd_valid_o,
   input  logic                       header_err_i,
   input  logic                       corr_header_err_i,
   input  logic                       crc_err_i,
   input  logic                       sof_i,
   input  logic                       eol_i,
   input  logic                       px_i,
   output logic                       phy_enable_o,
   output logic [SCCB_ADDR_WIDTH-1:0] sccb_slave_addr_o
`ifdef CSI2_CSR_ERR_IRQ_EN
   ,
   output logic                       err_irq_o
`endif
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   localparam addr_t A_CLR  = addr_t'(CLEAR_STAT_CR);
   localparam addr_t A_PHY  = addr_t'(PHY_ENABLE_CR);
   localparam addr_t A_SCCB = addr_t'(SCCB_SLAVE_ADDR_CR);
   localparam addr_t A_HERR = addr_t'(SR_BASE + HEADER_ERR_CNT_SR);
   localparam addr_t A_CERR = addr_t'(SR_BASE + CORR_HEADER_ERR_CNT_SR);
   localparam addr_t A_CRC  = addr_t'(SR_BASE + CRC_ERR_CNT_SR);
   localparam addr_t A_MXLN = addr_t'(SR_BASE + MAX_LN_PER_FRAME_SR);
   localparam addr_t A_MNLN = addr_t'(SR_BASE + MIN_LN_PER_FRAME_SR);
   localparam addr_t A_MXPX = addr_t'(SR_BASE + MAX_PX_PER_LN_SR);
   localparam addr_t A_MNPX = addr_t'(SR_BASE + MIN_PX_PER_LN_SR);

   logic                       clear_q, clear_d;
   logic                       phy_q, phy_d;
   logic [SCCB_ADDR_WIDTH-1:0] sccb_q, sccb_d;
   logic [DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
   logic                       rd_valid_q;
   logic [DATA_WIDTH-1:0]      rd_mux;
   logic                       wr_clr;

   logic [ERR_CNT-1:0]                ev;
   logic [ERR_CNT-1:0][CNT_WIDTH-1:0] err_q, err_d;

   logic [CNT_WIDTH-1:0] ln_max, ln_min;
   logic [CNT_WIDTH-1:0] px_max, px_min;

   // write-data bits above the widest field carry no state
   logic unused_wdata;
   assign unused_wdata = ^csr_wr_data_i[DATA_WIDTH-1:SCCB_ADDR_WIDTH];

   assign ev[ERR_HDR]  = header_err_i;
   assign ev[ERR_CORR] = corr_header_err_i;
   assign ev[ERR_CRC]  = crc_err_i;

   assign wr_clr = csr_wr_i && (csr_addr_i == A_CLR);

   always_comb begin
      clear_d = wr_clr && csr_wr_data_i[CLR_STAT_BIT];
      phy_d   = phy_q;
      sccb_d  = sccb_q;
      if (csr_wr_i && csr_addr_i == A_PHY)
         phy_d = csr_wr_data_i[0];
      if (csr_wr_i && csr_addr_i == A_SCCB)
         sccb_d = csr_wr_data_i[SCCB_ADDR_WIDTH-1:0];
   end

   // error counters: the clear pulse wins over a same-cycle event
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < ERR_CNT; i++) begin
         if (clear_q)
            err_d[i] = '0;
         else if (ev[i] && !(&err_q[i]))
            err_d[i] = err_q[i] + 1'b1;
      end
   end

   csi2_minmax_tracker #(
      .W          (CNT_WIDTH),
      .INCL_COUNT (1'b0),
      .NEED_ARM   (1'b1)
   ) u_ln (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (clear_q),
      .count_i  (eol_i),
      .commit_i (sof_i),
      .arm_i    (sof_i),
      .max_o    (ln_max),
      .min_o    (ln_min)
   );

   csi2_minmax_tracker #(
      .W          (CNT_WIDTH),
      .INCL_COUNT (1'b1),
      .NEED_ARM   (1'b0)
   ) u_px (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (clear_q),
      .count_i  (px_i),
      .commit_i (eol_i),
      .arm_i    (1'b0),
      .max_o    (px_max),
      .min_o    (px_min)
   );

`ifdef CSI2_CSR_ERR_IRQ_EN
   localparam addr_t A_MASK = addr_t'(IRQ_MASK_CR);

   logic [ERR_CNT-1:0] mask_q, mask_d;
   logic               irq_q, irq_d;

   always_comb begin
      mask_d = mask_q;
      if (csr_wr_i && csr_addr_i == A_MASK)
         mask_d = csr_wr_data_i[ERR_CNT-1:0];
      // a new unmasked error beats a same-cycle clear
      irq_d = (|(ev & mask_q)) ||
              (irq_q && !(wr_clr && csr_wr_data_i[CLR_IRQ_BIT]));
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         irq_q  <= irq_d;
      end
   end

   assign err_irq_o = irq_q;
`endif

   always_comb begin
      rd_mux = '0;
      case (csr_addr_i)
         A_PHY:  rd_mux = DATA_WIDTH'(phy_q);
         A_SCCB: rd_mux = DATA_WIDTH'(sccb_q);
         A_HERR: rd_mux = DATA_WIDTH'(err_q[ERR_HDR]);
         A_CERR: rd_mux = DATA_WIDTH'(err_q[ERR_CORR]);
         A_CRC:  rd_mux = DATA_WIDTH'(err_q[ERR_CRC]);
         A_MXLN: rd_mux = DATA_WIDTH'(ln_max);
         A_MNLN: rd_mux = DATA_WIDTH'(ln_min);
         A_MXPX: rd_mux = DATA_WIDTH'(px_max);
         A_MNPX: rd_mux = DATA_WIDTH'(px_min);
`ifdef CSI2_CSR_ERR_IRQ_EN
         A_MASK: rd_mux = DATA_WIDTH'(mask_q);
`endif
         default: rd_mux = '0;
      endcase
      rd_data_d = csr_rd_i ? rd_mux : '0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         clear_q    <= 1'b0;
         phy_q      <= 1'b0;
         sccb_q     <= '0;
         err_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         clear_q    <= clear_d;
         phy_q      <= phy_d;
         sccb_q     <= sccb_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= csr_rd_i;
      end
   end

   assign csr_rd_data_o     = rd_data_q;
   assign csr_rd_valid_o    = rd_valid_q;
   assign phy_enable_o      = phy_q;
   assign sccb_slave_addr_o = sccb_q;

endmodule

// File: tb/tb_csi2_csr_stat.sv
// Bench for csi2_csr_stat: two instances (CNT_WIDTH 16 and 4) against a
// behavioural model; covers CSI2_CSR_ERR_IRQ_EN when that macro is defined.
module tb_csi2_csr_stat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  addr = '0;
   logic        wr = 1'b0;
   logic [31:0] wdata = '0;
   logic        rd = 1'b0;
   logic        hdr = 1'b0, corr = 1'b0, crc = 1'b0;
   logic        sof = 1'b0, eol = 1'b0, px = 1'b0;

   logic [31:0] rdat [2];
   logic        rval [2];
   logic        phy  [2];
   logic [6:0]  sccb [2];
`ifdef CSI2_CSR_ERR_IRQ_EN
   logic        irq  [2];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   csi2_csr_stat #(.CNT_WIDTH(16)) dut0 (
      .clk_i(clk), .rst_n_i(rst_n),
      .csr_addr_i(addr), .csr_wr_i(wr), .csr_wr_data_i(wdata),
      .csr_rd_i(rd), .csr_rd_data_o(rdat[0]), .csr_rd_valid_o(rval[0]),
      .header_err_i(hdr), .corr_header_err_i(corr), .crc_err_i(crc),
      .sof_i(sof), .eol_i(eol), .px_i(px),
      .phy_enable_o(phy[0]), .sccb_slave_addr_o(sccb[0])
`ifdef CSI2_CSR_ERR_IRQ_EN
      , .err_irq_o(irq[0])
`endif
   );

   csi2_csr_stat #(.CNT_WIDTH(4)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n),
      .csr_addr_i(addr), .csr_wr_i(wr), .csr_wr_data_i(wdata),
      .csr_rd_i(rd), .csr_rd_data_o(rdat[1]), .csr_rd_valid_o(rval[1]),
      .header_err_i(hdr), .corr_header_err_i(corr), .crc_err_i(crc),
      .sof_i(sof), .eol_i(eol), .px_i(px),
      .phy_enable_o(phy[1]), .sccb_slave_addr_o(sccb[1])
`ifdef CSI2_CSR_ERR_IRQ_EN
      , .err_irq_o(irq[1])
`endif
   );

   // ---------------- behavioural model ----------------
   localparam int MAXV [2] = '{65535, 15};

   int herr[2], cerr[2], crcn[2];
   int mxln[2], mnln[2], mxpx[2], mnpx[2];
   int lnacc[2], pxacc[2];
   bit armed[2];
   int phy_m, sccb_m, mask_m;
   bit irq_m, clr_pend;
   bit exp_valid;
   int exp_data[2];
`ifdef CSI2_CSR_ERR_IRQ_EN
   localparam bit HAS_IRQ = 1'b1;
`else
   localparam bit HAS_IRQ = 1'b0;
`endif

   function automatic int sat(int v, int m);
      return (v > m) ? m : v;
   endfunction

   function automatic void stats_reset();
      for (int m = 0; m < 2; m++) begin
         herr[m] = 0; cerr[m] = 0; crcn[m] = 0;
         mxln[m] = 0; mnln[m] = MAXV[m];
         mxpx[m] = 0; mnpx[m] = MAXV[m];
         lnacc[m] = 0; pxacc[m] = 0; armed[m] = 0;
      end
   endfunction

   function automatic int mread(int m, int a);
      case (a)
         1: return phy_m;
         2: return sccb_m;
         3: return herr[m];
         4: return cerr[m];
         5: return crcn[m];
         6: return mxln[m];
         7: return mnln[m];
         8: return mxpx[m];
         9: return mnpx[m];
         10: return HAS_IRQ ? mask_m : 0;
         default: return 0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         stats_reset();
         phy_m = 0; sccb_m = 0; mask_m = 0;
         irq_m = 0; clr_pend = 0; exp_valid = 0;
         exp_data[0] = 0; exp_data[1] = 0;
      end else begin
         int a;
         int v;
         bit set;
         a = int'(addr);
         exp_valid = rd;
         for (int m = 0; m < 2; m++)
            exp_data[m] = rd ? mread(m, a) : 0;
         set = (hdr && mask_m[0]) || (corr && mask_m[1]) ||
               (crc && mask_m[2]);
         if (set) irq_m = 1;
         else if (wr && a == 0 && wdata[1]) irq_m = 0;
         if (wr && a == 1) phy_m = int'(wdata[0]);
         if (wr && a == 2) sccb_m = int'(wdata[6:0]);
         if (wr && a == 10) mask_m = int'(wdata[2:0]);
         if (clr_pend) begin
            stats_reset();
         end else begin
            for (int m = 0; m < 2; m++) begin
               if (hdr)  herr[m] = sat(herr[m] + 1, MAXV[m]);
               if (corr) cerr[m] = sat(cerr[m] + 1, MAXV[m]);
               if (crc)  crcn[m] = sat(crcn[m] + 1, MAXV[m]);
               if (eol) begin
                  v = sat(pxacc[m] + (px ? 1 : 0), MAXV[m]);
                  if (v > mxpx[m]) mxpx[m] = v;
                  if (v < mnpx[m]) mnpx[m] = v;
                  pxacc[m] = 0;
               end else if (px) begin
                  pxacc[m] = sat(pxacc[m] + 1, MAXV[m]);
               end
               if (sof) begin
                  if (armed[m]) begin
                     if (lnacc[m] > mxln[m]) mxln[m] = lnacc[m];
                     if (lnacc[m] < mnln[m]) mnln[m] = lnacc[m];
                  end
                  armed[m] = 1;
                  lnacc[m] = eol ? 1 : 0;
               end else if (eol) begin
                  lnacc[m] = sat(lnacc[m] + 1, MAXV[m]);
               end
            end
         end
         clr_pend = wr && a == 0 && wdata[0];
      end
   end

   task automatic chk(string name, int m, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h",
                  name, m, act, exp);
      end
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (rst_n) begin
         for (int m = 0; m < 2; m++) begin
            chk("rd_valid", m, longint'(rval[m]), longint'(exp_valid));
            if (exp_valid)
               chk("rd_data", m, longint'(rdat[m]),
                   longint'(exp_data[m]));
            chk("phy_enable", m, longint'(phy[m]), longint'(phy_m));
            chk("sccb_addr", m, longint'(sccb[m]), longint'(sccb_m));
`ifdef CSI2_CSR_ERR_IRQ_EN
            chk("err_irq", m, longint'(irq[m]), longint'(irq_m));
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      wr = 0; rd = 0;
      hdr = 0; corr = 0; crc = 0;
      sof = 0; eol = 0; px = 0;
   endtask

   task automatic csr_write(int a, int d);
      addr = 8'(a); wdata = 32'(d); wr = 1;
      step();
   endtask

   task automatic csr_read(int a);
      addr = 8'(a); rd = 1;
      step();
   endtask

   task automatic read_lit(int m, int a, longint exp);
      csr_read(a);
      chk($sformatf("lit_word%0d", a), m, longint'(rdat[m]), exp);
   endtask

   initial begin
      repeat (3) begin
         @(negedge clk);
         chk("reset_rd_valid", 0, longint'(rval[0]), 0);
         chk("reset_phy", 0, longint'(phy[0]), 0);
         chk("reset_sccb", 1, longint'(sccb[1]), 0);
      end
      @(posedge clk);
      #1 rst_n = 1;

      // reset readback, back to back
      for (int a = 0; a <= 11; a++) csr_read(a);
      read_lit(0, 7, 'hFFFF);
      read_lit(1, 9, 'hF);
      read_lit(0, 3, 0);
      read_lit(0, 10, 0);

      // control registers
      csr_write(1, 1);
      chk("lit_phy", 0, longint'(phy[0]), 1);
      csr_write(2, 'h3C);
      chk("lit_sccb", 0, longint'(sccb[0]), 'h3C);
      read_lit(0, 1, 1);
      read_lit(0, 2, 'h3C);
      csr_write(0, 0);
      read_lit(0, 0, 0);
      // write and read together: read sees pre-write value
      addr = 8'd2; wdata = 32'h55; wr = 1; rd = 1;
      step();
      chk("lit_rd_wr", 0, longint'(rdat[0]), 'h3C);
      csr_write(2, 'h3C);

      // error counters
      repeat (5) begin hdr = 1; step(); end
      repeat (2) begin crc = 1; step(); end
      repeat (3) begin corr = 1; step(); end
      read_lit(0, 3, 5);
      read_lit(0, 4, 3);
      read_lit(0, 5, 2);
      repeat (18) begin crc = 1; step(); end
      read_lit(1, 5, 15);
      read_lit(0, 5, 20);

      // pixels per line: 640 (last px with eol), then 642
      repeat (639) begin px = 1; step(); end
      px = 1; eol = 1; step();
      repeat (642) begin px = 1; step(); end
      eol = 1; step();
      read_lit(0, 8, 642);
      read_lit(0, 9, 640);
      read_lit(1, 9, 15);

      // clear coinciding with events, then events in pulse cycle
      hdr = 1; eol = 1; px = 1;
      csr_write(0, 1);
      hdr = 1; crc = 1; eol = 1; px = 1; sof = 1;
      step();
      for (int a = 0; a <= 10; a++) csr_read(a);
      read_lit(0, 3, 0);
      read_lit(0, 5, 0);
      read_lit(0, 7, 'hFFFF);
      read_lit(0, 8, 0);
      read_lit(0, 9, 'hFFFF);

      // lines per frame: 480 then 478 lines
      sof = 1; step();
      read_lit(0, 7, 'hFFFF);
      repeat (480) begin eol = 1; px = 1; step(); end
      sof = 1; step();
      repeat (478) begin eol = 1; step(); end
      sof = 1; step();
      read_lit(0, 6, 480);
      read_lit(0, 7, 478);
      read_lit(1, 6, 15);

`ifdef CSI2_CSR_ERR_IRQ_EN
      csr_write(10, 4);
      read_lit(0, 10, 4);
      hdr = 1; step();
      chk("lit_irq_masked", 0, longint'(irq[0]), 0);
      crc = 1; step();
      chk("lit_irq_set", 0, longint'(irq[0]), 1);
      repeat (3) step();
      chk("lit_irq_sticky", 0, longint'(irq[0]), 1);
      csr_write(0, 2);
      chk("lit_irq_clr", 0, longint'(irq[0]), 0);
      crc = 1; wr = 1; addr = 8'd0; wdata = 32'd2; step();
      chk("lit_irq_setwins", 0, longint'(irq[0]), 1);
      csr_write(10, 7);
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         hdr  = ($urandom_range(9, 0) == 0);
         corr = ($urandom_range(9, 0) == 0);
         crc  = ($urandom_range(9, 0) == 0);
         px   = ($urandom_range(3, 0) != 0);
         eol  = ($urandom_range(7, 0) == 0);
         sof  = ($urandom_range(40, 0) == 0);
         rd   = ($urandom_range(2, 0) == 0);
         addr = 8'($urandom_range(12, 0));
         if ($urandom_range(30, 0) == 0) begin
            wr = 1;
            wdata = $urandom();
            if ($urandom_range(3, 0) == 0) addr = 8'd0;
         end
         step();
      end
      for (int a = 0; a <= 11; a++) csr_read(a);
      repeat (2) step();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
